// File: rtl/aes_sub_shift.sv
// Iterative AES SubBytes+ShiftRows (forward and inverse): one state row per cycle
// through four shared S-box lanes, result held until the consumer takes it.
module aes_sub_shift (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         fwd_ninv_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] block_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] block_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q;
    logic [1:0]   cnt_q;
    logic         fwd_q;
    logic         rdy_q;
    logic         valid_q;
    logic [127:0] in_q;
    logic [127:0] out_q;
    logic [127:0] out_d;
    logic [31:0]  row_w;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (maps 0 to 0 without a special case).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x14  = gf_mul(x12, x2);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(x240, x14);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    // One lane shares the field inversion between both directions.
    function automatic logic [7:0] sbox_lane(input logic [7:0] a, input logic fwd);
        logic [7:0] pre;
        logic [7:0] inv;
        pre = fwd ? a : inv_affine(a);
        inv = gf_inv(pre);
        return fwd ? affine(inv) : inv;
    endfunction

    always_comb begin
        row_w = in_q[127:96];
        unique case (cnt_q)
            2'd0: row_w = in_q[127:96];
            2'd1: row_w = in_q[95:64];
            2'd2: row_w = in_q[63:32];
            2'd3: row_w = in_q[31:0];
            default: row_w = in_q[127:96];
        endcase
    end

    // Forward rotates left by cnt bytes, inverse rotates right.
    always_comb begin
        rot_w = row_w;
        unique case (cnt_q)
            2'd0: rot_w = row_w;
            2'd1: rot_w = fwd_q ? {row_w[23:0], row_w[31:24]} : {row_w[7:0], row_w[31:8]};
            2'd2: rot_w = {row_w[15:0], row_w[31:16]};
            2'd3: rot_w = fwd_q ? {row_w[7:0], row_w[31:8]} : {row_w[23:0], row_w[31:24]};
            default: rot_w = row_w;
        endcase
    end

    always_comb begin
        sub_w = 32'h0;
        for (int c = 0; c < 4; c++) begin
            sub_w[31-8*c -: 8] = sbox_lane(rot_w[31-8*c -: 8], fwd_q);
        end
    end

    always_comb begin
        out_d = out_q;
        unique case (cnt_q)
            2'd0: out_d[127:96] = sub_w;
            2'd1: out_d[95:64]  = sub_w;
            2'd2: out_d[63:32]  = sub_w;
            2'd3: out_d[31:0]   = sub_w;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            fwd_q   <= 1'b1;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            in_q    <= 128'h0;
            out_q   <= 128'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    rdy_q <= 1'b1;
                    if (in_valid_i && rdy_q) begin
                        in_q    <= block_i;
                        fwd_q   <= fwd_ninv_i;
                        cnt_q   <= 2'd0;
                        rdy_q   <= 1'b0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    out_q <= out_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        valid_q <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    rdy_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = valid_q;
    assign block_o     = out_q;

endmodule

// File: tb/tb_aes_sub_shift.sv
// Self-checking bench for aes_sub_shift: directed FIPS-197 vectors, back-pressure,
// async reset and a randomized stream against a table-driven reference model.
module tb_aes_sub_shift;

    logic         clk;
    logic         rst_n;
    logic         fwd;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] blk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] blk_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    localparam logic [127:0] AppBIn  = 128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08;
    localparam logic [127:0] AppBOut = 128'hd4e0b81e_bfb44127_5d521198_30aef1e5;

    aes_sub_shift dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .fwd_ninv_i (fwd),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .block_i    (blk_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .block_o    (blk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = (t << 1) ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Tables built by brute-force inverse search plus the bitwise affine formula.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (xmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox[x] = s;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_model(input logic [127:0] b, input logic f);
        logic [7:0]   in_b [16];
        logic [127:0] r;
        for (int k = 0; k < 16; k++) in_b[k] = b[127-8*k -: 8];
        r = 0;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[127-8*(4*row+col) -: 8] = f ? sbox[in_b[4*row + (col+row)%4]]
                                              : isbox[in_b[4*row + (col-row+4)%4]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a block and returns at the negedge following the accepting edge.
    task automatic send(input string tag, input logic [127:0] b, input logic f);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        blk_in   = b;
        fwd      = f;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 128'(n < 20), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        blk_in   = {$urandom, $urandom, $urandom, $urandom};
        fwd      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input string tag, input logic [127:0] exp);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            fwd    = ~fwd;
            blk_in = ~blk_in;
            if (!out_valid) lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_data"}, blk_out, exp);
        chk({tag, "_ready_low"}, 128'(in_ready), 128'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
        chk({tag, "_ready_back"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] q[$];
        logic [127:0] held;
        logic [127:0] rb;
        int sent;
        int rcvd;
        int cyc;
        int last_acc;

        build_tables();
        rst_n     = 1'b0;
        fwd       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        blk_in    = '0;

        #12;
        chk("reset_ready", 128'(in_ready), 128'd0);
        chk("reset_valid", 128'(out_valid), 128'd0);
        chk("reset_block", blk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 128'(in_ready), 128'd1);

        send("appb_fwd", AppBIn, 1'b1);
        wait_result("appb_fwd", AppBOut);
        chk("appb_fwd_model", blk_out, ref_model(AppBIn, 1'b1));
        release_out("appb_fwd");

        send("appb_inv", AppBOut, 1'b0);
        wait_result("appb_inv", AppBIn);
        release_out("appb_inv");

        send("zero_fwd", 128'd0, 1'b1);
        wait_result("zero_fwd", {16{8'h63}});
        release_out("zero_fwd");

        send("zero_inv", 128'd0, 1'b0);
        wait_result("zero_inv", {16{8'h52}});
        release_out("zero_inv");

        // Back-pressure with inputs churning; mode must stay latched.
        rb = {$urandom, $urandom, $urandom, $urandom};
        send("hold", rb, 1'b0);
        wait_result("hold", ref_model(rb, 1'b0));
        held = blk_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            fwd      = ~fwd;
            blk_in   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("hold_block", blk_out, held);
            chk("hold_ready", 128'(in_ready), 128'd0);
            chk("hold_valid", 128'(out_valid), 128'd1);
        end
        release_out("hold");

        // Asynchronous reset between edges, mid-BUSY.
        send("rst_mid", {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'd0);
        chk("async_rst_block", blk_out, 128'd0);
        chk("async_rst_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("async_rst_release_ready", 128'(in_ready), 128'd1);
        chk("async_rst_release_valid", 128'(out_valid), 128'd0);
        send("appb_after_rst", AppBIn, 1'b1);
        wait_result("appb_after_rst", AppBOut);
        release_out("appb_after_rst");

        // Randomized stream with gaps on both sides.
        sent     = 0;
        rcvd     = 0;
        cyc      = 0;
        last_acc = -100;
        while (rcvd < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            blk_in    = {$urandom, $urandom, $urandom, $urandom};
            fwd       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                chk("stream_spacing", 128'(cyc - last_acc >= 5), 128'd1);
                last_acc = cyc;
                q.push_back(ref_model(blk_in, fwd));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("stream_pending", 128'(q.size() != 0), 128'd1);
                if (q.size() != 0) chk("stream_data", blk_out, q.pop_front());
                rcvd++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_sent", 128'(sent), 128'd100);
        chk("stream_received", 128'(rcvd), 128'd100);
        chk("stream_leftover", 128'(q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
